mem_store_unit: RTL and testbench
=================================

// Module: mem_store_unit
// PURPOSE
//  Write-side counterpart of the load/writeback path: executes MIPS SB/SH/SW as Avalon-MM style
//  writes to data memory. Takes effective address from ALU, store data from rt, and instruction.
//  Drives address/write/byteenable/writedata and holds them stable while waitrequest is high.
//  Reports completion (end_of_store), misalignment (addr_error) and stalled-bus timeout (bus_error).
// PARAMETERS
//  TIMEOUT_CYCLES  255  max stalled cycles with waitrequest=1 before abort; 0 = never abort; <=65535
// PORTS
//  clk           in   1   clock; all logic on rising edge
//  reset         in   1   synchronous, active-high reset
//  start         in   1   valid store request; sampled only in IDLE
//  instr         in   32  instruction; opcode = instr[31:26]
//  alu_addr      in   32  effective byte address (base + offset)
//  rt_data       in   32  store data from register rt
//  waitrequest   in   1   memory stall; write accepted on an edge where write=1 and waitrequest=0
//  address       out  32  word-aligned address {alu_addr[31:2],2'b00}
//  write         out  1   write strobe
//  byteenable    out  4   active byte lanes; lane k = byte offset k (little-endian lanes)
//  writedata     out  32  store data shifted into the enabled lanes
//  busy          out  1   high while a write is outstanding (state WRITE)
//  end_of_store  out  1   one-cycle pulse: store accepted by memory
//  addr_error    out  1   one-cycle pulse: misaligned SH/SW, no bus write issued
//  bus_error     out  1   one-cycle pulse: timeout abort
// BEHAVIOUR
//  - Reset: all outputs 0 (address, writedata, byteenable, write, busy, pulses); state IDLE; timer 0.
//    Reset mid-write: write drops to 0 on the edge reset is sampled; no end_of_store generated.
//  - States: IDLE, WRITE. Pulses are registered, asserted in the cycle after the causing edge.
//  - IDLE: at edge with start=1, decode opcode:
//    SB 101000: be = 4'b0001 << a[1:0]; writedata = {4{rt[7:0]}}
//    SH 101001: a[0]=0 required; be = a[1] ? 4'b1100 : 4'b0011; writedata = {2{rt[15:0]}}
//    SW 101011: a[1:0]=00 required; be = 4'b1111; writedata = rt
//    legal -> register outputs, write=1, busy=1, go WRITE (latency 1 cycle start->write)
//    misaligned -> stay IDLE, addr_error=1 for one cycle, write stays 0
//    any other opcode -> ignored, no outputs change
//  - WRITE: address/writedata/byteenable/write held constant.
//    edge with waitrequest=0 -> write=0, busy=0, end_of_store=1 next cycle, go IDLE, timer cleared.
//    edge with waitrequest=1 -> timer += 1; if TIMEOUT_CYCLES!=0 and timer reaches TIMEOUT_CYCLES
//      -> write=0, busy=0, bus_error=1 next cycle, go IDLE, timer cleared.
//    start while in WRITE is ignored (not queued); caller must wait for busy=0.
//  - A new start may be accepted in the same cycle end_of_store is high (back-to-back: 1 idle cycle
//    between write strobes).
//  - byteenable/writedata/address retain last value after completion; only write is the strobe.
//  - Timer 16 bits, saturating at 65535; never wraps.
// TESTING
//  1 reset; SW a=0x100 rt=0xDEADBEEF start, waitrequest=0 -> next cycle write=1 addr=0x100
//    be=1111 wd=0xDEADBEEF; cycle after: write=0, end_of_store=1 for one cycle
//  2 SB a=0x203 rt=0x000000A5 -> addr=0x200 be=1000 wd=0xA5A5A5A5; SH a=0x202 rt=0x1234 ->
//    be=1100 wd=0x12341234
//  3 SW a=0x102 / SH a=0x101 -> addr_error pulse, write never asserted, busy=0
//  4 SW with waitrequest=1 for 5 cycles then 0 -> outputs stable all 6 write cycles,
//    end_of_store once; start pulsed mid-stall ignored
//  5 TIMEOUT_CYCLES=4, waitrequest held 1 -> write high 4 cycles, then bus_error pulse, write=0
//  6 reset asserted 2 cycles into a stalled write -> write=0, busy=0 after that edge,
//    no end_of_store; opcode 100011 (LW) with start -> no activity

Source files
------------

// File: rtl/mem_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_store_unit
// Description : Executes MIPS SB/SH/SW as Avalon-MM style writes; reports
//               completion, misaligned-store and stalled-bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic [31:0] alu_addr,
    input  logic [31:0] rt_data,
    input  logic        waitrequest,
    output logic [31:0] address,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic        busy,
    output logic        end_of_store,
    output logic        addr_error,
    output logic        bus_error
);

    localparam logic [5:0]  c_OP_SB      = 6'b101000;
    localparam logic [5:0]  c_OP_SH      = 6'b101001;
    localparam logic [5:0]  c_OP_SW      = 6'b101011;
    localparam logic [15:0] c_TIMEOUT    = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] c_TIMER_MAX  = 16'hFFFF;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_timer;
    logic [31:0] r_address;
    logic        r_write;
    logic [3:0]  r_byteenable;
    logic [31:0] r_writedata;
    logic        r_busy;
    logic        r_end_of_store;
    logic        r_addr_error;
    logic        r_bus_error;

    logic [5:0]  w_opcode;
    logic        w_legal;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic [15:0] w_timer_inc;
    logic        w_timeout_hit;

    assign w_opcode = instr[31:26];

    // Lane steering: replicate the store datum so every candidate lane carries it.
    always_comb begin
        w_legal    = 1'b0;
        w_misalign = 1'b0;
        w_be       = 4'b0000;
        w_wd       = 32'h0;
        case (w_opcode)
            c_OP_SB: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << alu_addr[1:0];
                w_wd    = {4{rt_data[7:0]}};
            end
            c_OP_SH: begin
                if (alu_addr[0]) begin
                    w_misalign = 1'b1;
                end else begin
                    w_legal = 1'b1;
                    w_be    = alu_addr[1] ? 4'b1100 : 4'b0011;
                    w_wd    = {2{rt_data[15:0]}};
                end
            end
            c_OP_SW: begin
                if (alu_addr[1:0] != 2'b00) begin
                    w_misalign = 1'b1;
                end else begin
                    w_legal = 1'b1;
                    w_be    = 4'b1111;
                    w_wd    = rt_data;
                end
            end
            default: begin
                w_legal    = 1'b0;
                w_misalign = 1'b0;
            end
        endcase
    end

    // Saturating increment: a stalled bus with timeout disabled must not wrap.
    assign w_timer_inc   = (r_timer == c_TIMER_MAX) ? r_timer : r_timer + 16'd1;
    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (w_timer_inc == c_TIMEOUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_timer        <= 16'd0;
            r_address      <= 32'h0;
            r_write        <= 1'b0;
            r_byteenable   <= 4'b0000;
            r_writedata    <= 32'h0;
            r_busy         <= 1'b0;
            r_end_of_store <= 1'b0;
            r_addr_error   <= 1'b0;
            r_bus_error    <= 1'b0;
        end else begin
            r_end_of_store <= 1'b0;
            r_addr_error   <= 1'b0;
            r_bus_error    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && w_legal) begin
                        r_address    <= {alu_addr[31:2], 2'b00};
                        r_byteenable <= w_be;
                        r_writedata  <= w_wd;
                        r_write      <= 1'b1;
                        r_busy       <= 1'b1;
                        r_timer      <= 16'd0;
                        r_state      <= S_WRITE;
                    end else if (start && w_misalign) begin
                        r_addr_error <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (!waitrequest) begin
                        r_write        <= 1'b0;
                        r_busy         <= 1'b0;
                        r_end_of_store <= 1'b1;
                        r_timer        <= 16'd0;
                        r_state        <= S_IDLE;
                    end else if (w_timeout_hit) begin
                        r_write     <= 1'b0;
                        r_busy      <= 1'b0;
                        r_bus_error <= 1'b1;
                        r_timer     <= 16'd0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_write <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign address      = r_address;
    assign write        = r_write;
    assign byteenable   = r_byteenable;
    assign writedata    = r_writedata;
    assign busy         = r_busy;
    assign end_of_store = r_end_of_store;
    assign addr_error   = r_addr_error;
    assign bus_error    = r_bus_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_store_unit
// Description : Directed self-checking bench for mem_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_store_unit;

    localparam logic [5:0] c_OP_SB = 6'b101000;
    localparam logic [5:0] c_OP_SH = 6'b101001;
    localparam logic [5:0] c_OP_SW = 6'b101011;
    localparam logic [5:0] c_OP_LW = 6'b100011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [31:0] alu_addr = 32'h0;
    logic [31:0] rt_data = 32'h0;
    logic        waitrequest = 1'b0;

    logic [31:0] address, t_address;
    logic        write, t_write;
    logic [3:0]  byteenable, t_byteenable;
    logic [31:0] writedata, t_writedata;
    logic        busy, t_busy;
    logic        eos, t_eos;
    logic        aerr, t_aerr;
    logic        berr, t_berr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_store_unit #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr),
        .alu_addr(alu_addr), .rt_data(rt_data), .waitrequest(waitrequest),
        .address(address), .write(write), .byteenable(byteenable),
        .writedata(writedata), .busy(busy), .end_of_store(eos),
        .addr_error(aerr), .bus_error(berr)
    );

    mem_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset(reset), .start(start), .instr(instr),
        .alu_addr(alu_addr), .rt_data(rt_data), .waitrequest(waitrequest),
        .address(t_address), .write(t_write), .byteenable(t_byteenable),
        .writedata(t_writedata), .busy(t_busy), .end_of_store(t_eos),
        .addr_error(t_aerr), .bus_error(t_berr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        start    = 1'b1;
        instr    = {op, 26'h0};
        alu_addr = a;
        rt_data  = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // {write, busy, end_of_store, addr_error, bus_error}
    function automatic logic [4:0] flags();
        return {write, busy, eos, aerr, berr};
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if ({address, byteenable, writedata, flags()} !== {32'h0, 4'h0, 32'h0, 5'b00000}) begin
            failures++;
            $display("FAIL reset_state got addr=%h be=%b wd=%h flags=%b want all zero",
                     address, byteenable, writedata, flags());
        end
        checks++;
        if ({t_write, t_busy, t_berr} !== 3'b000) begin
            failures++;
            $display("FAIL reset_state_to got %b want 000", {t_write, t_busy, t_berr});
        end
    endtask

    task automatic test_sw();
        waitrequest = 1'b0;
        request(c_OP_SW, 32'h100, 32'hDEADBEEF);
        tick();
        start = 1'b0;
        checks++;
        if ({address, byteenable, writedata, flags()} !== {32'h100, 4'b1111, 32'hDEADBEEF, 5'b11000}) begin
            failures++;
            $display("FAIL sw_issue got addr=%h be=%b wd=%h flags=%b want 100/1111/deadbeef/11000",
                     address, byteenable, writedata, flags());
        end
        tick();
        checks++;
        if ({address, flags()} !== {32'h100, 5'b00100}) begin
            failures++;
            $display("FAIL sw_done got addr=%h flags=%b want 100/00100", address, flags());
        end
        tick();
        checks++;
        if (flags() !== 5'b00000) begin
            failures++;
            $display("FAIL sw_eos_pulse got flags=%b want 00000", flags());
        end
    endtask

    task automatic test_back_to_back();
        request(c_OP_SB, 32'h203, 32'h000000A5);
        tick();
        start = 1'b0;
        checks++;
        if ({address, byteenable, writedata, write} !== {32'h200, 4'b1000, 32'hA5A5A5A5, 1'b1}) begin
            failures++;
            $display("FAIL sb_issue got addr=%h be=%b wd=%h wr=%b want 200/1000/a5a5a5a5/1",
                     address, byteenable, writedata, write);
        end
        tick();
        checks++;
        if ({write, eos} !== 2'b01) begin
            failures++;
            $display("FAIL sb_done got wr/eos=%b want 01", {write, eos});
        end
        // New request presented in the end_of_store cycle.
        request(c_OP_SH, 32'h202, 32'h00001234);
        tick();
        start = 1'b0;
        checks++;
        if ({address, byteenable, writedata, write} !== {32'h200, 4'b1100, 32'h12341234, 1'b1}) begin
            failures++;
            $display("FAIL sh_b2b_issue got addr=%h be=%b wd=%h wr=%b want 200/1100/12341234/1",
                     address, byteenable, writedata, write);
        end
        tick();
        checks++;
        if ({write, eos} !== 2'b01) begin
            failures++;
            $display("FAIL sh_done got wr/eos=%b want 01", {write, eos});
        end
        tick();
    endtask

    task automatic test_misalign();
        request(c_OP_SW, 32'h102, 32'h11223344);
        tick();
        start = 1'b0;
        checks++;
        if ({flags(), address} !== {5'b00010, 32'h200}) begin
            failures++;
            $display("FAIL sw_misalign got flags=%b addr=%h want 00010/200", flags(), address);
        end
        tick();
        request(c_OP_SH, 32'h101, 32'h5566);
        tick();
        start = 1'b0;
        checks++;
        if (flags() !== 5'b00010) begin
            failures++;
            $display("FAIL sh_misalign got flags=%b want 00010", flags());
        end
        tick();
        checks++;
        if (flags() !== 5'b00000) begin
            failures++;
            $display("FAIL misalign_pulse got flags=%b want 00000", flags());
        end
    endtask

    task automatic test_stall();
        int n_eos = 0;
        waitrequest = 1'b1;
        request(c_OP_SW, 32'h300, 32'hCAFEF00D);
        tick();
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if ({address, byteenable, writedata, flags()} !== {32'h300, 4'b1111, 32'hCAFEF00D, 5'b11000}) begin
                failures++;
                $display("FAIL stall_hold[%0d] got addr=%h be=%b wd=%h flags=%b want 300/1111/cafef00d/11000",
                         i, address, byteenable, writedata, flags());
            end
            if (i == 2) request(c_OP_SB, 32'h404, 32'h77);
            tick();
            start = 1'b0;
        end
        checks++;
        if ({address, flags()} !== {32'h300, 5'b11000}) begin
            failures++;
            $display("FAIL stall_hold[6] got addr=%h flags=%b want 300/11000", address, flags());
        end
        waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (eos) n_eos++;
        end
        checks++;
        if ({n_eos, address, write} !== {32'd1, 32'h300, 1'b0}) begin
            failures++;
            $display("FAIL stall_complete got eos_count=%0d addr=%h wr=%b want 1/300/0",
                     n_eos, address, write);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        waitrequest = 1'b1;
        request(c_OP_SW, 32'h400, 32'h11112222);
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if ({t_write, t_busy, t_berr} !== 3'b110) begin
                failures++;
                $display("FAIL timeout_wr_cycle[%0d] got %b want 110", i, {t_write, t_busy, t_berr});
            end
            tick();
        end
        checks++;
        if ({t_write, t_busy, t_berr, t_eos} !== 4'b0010) begin
            failures++;
            $display("FAIL timeout_abort got %b want 0010", {t_write, t_busy, t_berr, t_eos});
        end
        checks++;
        if ({write, busy, berr} !== 3'b110) begin
            failures++;
            $display("FAIL timeout_255_still_waiting got %b want 110", {write, busy, berr});
        end
        tick();
        checks++;
        if ({t_write, t_berr} !== 2'b00) begin
            failures++;
            $display("FAIL timeout_pulse got %b want 00", {t_write, t_berr});
        end
    endtask

    task automatic test_reset_mid_write();
        int n_eos = 0;
        do_reset();
        waitrequest = 1'b1;
        request(c_OP_SW, 32'h600, 32'hA1B2C3D4);
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({write, busy, address} !== {1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_mid_write got wr=%b busy=%b addr=%h want 0/0/0", write, busy, address);
        end
        reset = 1'b0;
        waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (eos) n_eos++;
        end
        checks++;
        if (n_eos !== 0) begin
            failures++;
            $display("FAIL reset_no_eos got eos_count=%0d want 0", n_eos);
        end
        request(c_OP_LW, 32'h500, 32'h99999999);
        tick();
        start = 1'b0;
        checks++;
        if ({flags(), address, byteenable, writedata} !== {5'b00000, 32'h0, 4'h0, 32'h0}) begin
            failures++;
            $display("FAIL lw_ignored got flags=%b addr=%h be=%b wd=%h want all zero",
                     flags(), address, byteenable, writedata);
        end
        tick();
        checks++;
        if (flags() !== 5'b00000) begin
            failures++;
            $display("FAIL lw_ignored_late got flags=%b want 00000", flags());
        end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_back_to_back();
        test_misalign();
        test_stall();
        test_timeout();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
